// File: rtl/iop_xfer_ctrl.sv
// AHB-to-IOP transfer controller: minimum wait states, illegal-access and timeout
// ERROR responses. Optional timeout logic is enabled by IOP_XFER_CTRL_TIMEOUT_EN.
module iop_xfer_ctrl #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [11:0] ADDR_LIMIT  = 12'h400,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        IOSEL,
  input  logic        IOTRANS,
  input  logic        IOWRITE,
  input  logic [1:0]  IOSIZE,
  input  logic [11:0] IOADDR,
  input  logic        PERIPH_READY,
  output logic        IOSEL_GATED,
  output logic        READY,
  output logic        RESPONSE,
  output logic        ERR_PULSE,
  output logic [1:0]  ERR_CAUSE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ERR2 = 2'b10
  } state_t;

  localparam logic [3:0] WCNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [1:0] cause_q, cause_d;

  logic start, size_err, range_err, illegal, done;

  // Direction is carried for status only; no decision depends on it.
  logic unused_iowrite;
  assign unused_iowrite = IOWRITE;

  assign start     = IOSEL & IOTRANS;
  assign size_err  = (IOSIZE == 2'b11) |
                     ((IOSIZE == 2'b01) & IOADDR[0]) |
                     ((IOSIZE == 2'b10) & (|IOADDR[1:0]));
  assign range_err = (IOADDR >= ADDR_LIMIT);
  assign illegal   = size_err | range_err;
  assign done      = (wcnt_q == 4'd0) & PERIPH_READY;

  assign IOSEL_GATED = IOSEL & ~illegal;
  assign ERR_CAUSE   = cause_q;

`ifdef IOP_XFER_CTRL_TIMEOUT_EN
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tcnt_q, tcnt_d;
  logic       timeout;
  assign timeout = (tcnt_q == TCNT_LAST);
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    cause_d   = cause_q;
    READY     = 1'b1;
    RESPONSE  = 1'b0;
    ERR_PULSE = 1'b0;
`ifdef IOP_XFER_CTRL_TIMEOUT_EN
    tcnt_d    = tcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (illegal) begin
            READY     = 1'b0;
            RESPONSE  = 1'b1;
            ERR_PULSE = 1'b1;
            cause_d   = size_err ? 2'b01 : 2'b10;
            state_d   = S_ERR2;
          end else if (!((WAIT_STATES == 0) && PERIPH_READY)) begin
            READY   = 1'b0;
            wcnt_d  = WCNT_INIT;
`ifdef IOP_XFER_CTRL_TIMEOUT_EN
            tcnt_d  = '0;
`endif
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (done) begin
          state_d = S_IDLE;
`ifdef IOP_XFER_CTRL_TIMEOUT_EN
        end else if (timeout) begin
          READY     = 1'b0;
          RESPONSE  = 1'b1;
          ERR_PULSE = 1'b1;
          cause_d   = 2'b11;
          state_d   = S_ERR2;
`endif
        end else begin
          READY = 1'b0;
          if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
`ifdef IOP_XFER_CTRL_TIMEOUT_EN
          tcnt_d = tcnt_q + 8'd1;
`endif
        end
      end
      S_ERR2: begin
        RESPONSE = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cause_q <= cause_d;
    end
  end

`ifdef IOP_XFER_CTRL_TIMEOUT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) tcnt_q <= '0;
    else          tcnt_q <= tcnt_d;
  end
`endif

endmodule

// File: tb/tb_iop_xfer_ctrl.sv
// Directed self-checking bench for iop_xfer_ctrl (zero- and two-wait-state instances).
module tb_iop_xfer_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        IOSEL, IOTRANS, IOWRITE, PERIPH_READY;
  logic [1:0]  IOSIZE;
  logic [11:0] IOADDR;

  logic        g0, r0, s0, p0;
  logic [1:0]  c0;
  logic        g2, r2, s2, p2;
  logic [1:0]  c2;

  int n_vec = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  iop_xfer_ctrl #(.WAIT_STATES(0), .ADDR_LIMIT(12'h400), .TIMEOUT(8)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .IOSEL(IOSEL), .IOTRANS(IOTRANS),
    .IOWRITE(IOWRITE), .IOSIZE(IOSIZE), .IOADDR(IOADDR),
    .PERIPH_READY(PERIPH_READY), .IOSEL_GATED(g0), .READY(r0),
    .RESPONSE(s0), .ERR_PULSE(p0), .ERR_CAUSE(c0)
  );

  iop_xfer_ctrl #(.WAIT_STATES(2), .ADDR_LIMIT(12'h400), .TIMEOUT(8)) u2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .IOSEL(IOSEL), .IOTRANS(IOTRANS),
    .IOWRITE(IOWRITE), .IOSIZE(IOSIZE), .IOADDR(IOADDR),
    .PERIPH_READY(PERIPH_READY), .IOSEL_GATED(g2), .READY(r2),
    .RESPONSE(s2), .ERR_PULSE(p2), .ERR_CAUSE(c2)
  );

  typedef struct {
    logic        s, t;
    logic [1:0]  sz;
    logic [11:0] a;
    logic        pr;
    logic        er, es, eg, ep;
    logic [1:0]  ec;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic t, input logic [1:0] sz,
                       input logic [11:0] a, input logic pr);
    IOSEL = s; IOTRANS = t; IOSIZE = sz; IOADDR = a; PERIPH_READY = pr;
    IOWRITE = 1'b0;
  endtask

  // One data-phase cycle: inputs change just after the edge, outputs checked at negedge.
  task automatic cyc(input logic s, input logic t, input logic [1:0] sz,
                     input logic [11:0] a, input logic pr);
    @(posedge HCLK); #1;
    drive(s, t, sz, a, pr);
    @(negedge HCLK);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 2'b00, 12'h000, 1'b1);
  endtask

  initial begin
    //          s  t  sz     addr     pr   rdy  rsp  gat  pls  cause
    tbl[0]  = '{1, 1, 2'b10, 12'h004, 1,   1,   0,   1,   0,   2'b00};
    tbl[1]  = '{1, 0, 2'b10, 12'h004, 1,   1,   0,   1,   0,   2'b00};
    tbl[2]  = '{0, 1, 2'b11, 12'h000, 1,   1,   0,   0,   0,   2'b00};
    tbl[3]  = '{1, 1, 2'b01, 12'h003, 1,   0,   1,   0,   1,   2'b01};
    tbl[4]  = '{1, 1, 2'b10, 12'h400, 1,   0,   1,   0,   1,   2'b10};
    tbl[5]  = '{1, 1, 2'b10, 12'h002, 1,   0,   1,   0,   1,   2'b01};
    tbl[6]  = '{1, 1, 2'b00, 12'h3FF, 1,   1,   0,   1,   0,   2'b01};
    tbl[7]  = '{1, 1, 2'b01, 12'h400, 1,   0,   1,   0,   1,   2'b10};
    tbl[8]  = '{1, 1, 2'b11, 12'h000, 1,   0,   1,   0,   1,   2'b01};
    tbl[9]  = '{1, 1, 2'b10, 12'hFFC, 1,   0,   1,   0,   1,   2'b10};
    tbl[10] = '{1, 1, 2'b01, 12'h401, 1,   0,   1,   0,   1,   2'b01};
    tbl[11] = '{1, 1, 2'b10, 12'h3FC, 0,   0,   0,   1,   0,   2'b01};
    tbl[12] = '{1, 0, 2'b11, 12'h000, 0,   1,   0,   0,   0,   2'b01};

    // Reset state
    drive(1'b0, 1'b0, 2'b10, 12'h004, 1'b1);
    #12;
    chk("rst_ready", r0, 1); chk("rst_resp", s0, 0);
    chk("rst_pulse", p0, 0); chk("rst_cause", c0, 0);
    chk("rst_ready_ws2", r2, 1); chk("rst_cause_ws2", c2, 0);
    drive(1'b1, 1'b0, 2'b10, 12'h004, 1'b1); #1;
    chk("rst_gated_legal", g0, 1);
    drive(1'b1, 1'b0, 2'b10, 12'h401, 1'b1); #1;
    chk("rst_gated_illegal", g0, 0);
    drive(1'b0, 1'b0, 2'b00, 12'h000, 1'b1);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    idle(1);

    // Single-cycle D0 behaviour of the zero-wait instance, then drain
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].s, tbl[i].t, tbl[i].sz, tbl[i].a, tbl[i].pr);
      chk($sformatf("v%0d_ready", i), r0, tbl[i].er);
      chk($sformatf("v%0d_resp", i), s0, tbl[i].es);
      chk($sformatf("v%0d_gated", i), g0, tbl[i].eg);
      chk($sformatf("v%0d_pulse", i), p0, tbl[i].ep);
      idle(1);
      chk($sformatf("v%0d_d1_ready", i), r0, 1);
      chk($sformatf("v%0d_d1_resp", i), s0, tbl[i].ep);
      chk($sformatf("v%0d_d1_pulse", i), p0, 0);
      chk($sformatf("v%0d_cause", i), c0, tbl[i].ec);
      idle(2);
    end

    // Two wait states, peripheral always ready: completes in D2
    cyc(1, 1, 2'b10, 12'h004, 1); chk("ws2_d0_ready", r2, 0);
    cyc(1, 1, 2'b10, 12'h004, 1); chk("ws2_d1_ready", r2, 0);
    cyc(1, 1, 2'b10, 12'h004, 1); chk("ws2_d2_ready", r2, 1); chk("ws2_d2_resp", s2, 0);
    idle(2);

    // Two wait states, peripheral first ready in D4
    for (int d = 0; d < 4; d++) begin
      cyc(1, 1, 2'b10, 12'h004, 0);
      chk($sformatf("ws2_slow_d%0d_ready", d), r2, 0);
      chk($sformatf("ws2_slow_d%0d_resp", d), s2, 0);
    end
    cyc(1, 1, 2'b10, 12'h004, 1); chk("ws2_slow_d4_ready", r2, 1);
    idle(2);

    // Error followed by back-to-back legal transfers; ERR2 ignores its inputs
    cyc(1, 1, 2'b11, 12'h000, 1);
    chk("b2b_d0_ready", r0, 0); chk("b2b_d0_resp", s0, 1); chk("b2b_d0_pulse", p0, 1);
    cyc(1, 1, 2'b10, 12'h004, 1);
    chk("b2b_d1_ready", r0, 1); chk("b2b_d1_resp", s0, 1); chk("b2b_d1_pulse", p0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 2'b10, 12'h004, 1);
      chk($sformatf("b2b_x%0d_ready", k), r0, 1);
      chk($sformatf("b2b_x%0d_resp", k), s0, 0);
    end
    idle(3);

    // Stuck peripheral
    cyc(1, 1, 2'b10, 12'h004, 0); chk("to_d0_ready", r0, 0);
`ifdef IOP_XFER_CTRL_TIMEOUT_EN
    for (int d = 1; d < 8; d++) begin
      cyc(1, 1, 2'b10, 12'h004, 0);
      chk($sformatf("to_d%0d_ready", d), r0, 0);
      chk($sformatf("to_d%0d_resp", d), s0, 0);
      chk($sformatf("to_d%0d_pulse", d), p0, 0);
    end
    cyc(1, 1, 2'b10, 12'h004, 0);
    chk("to_d8_ready", r0, 0); chk("to_d8_resp", s0, 1); chk("to_d8_pulse", p0, 1);
    cyc(0, 0, 2'b00, 12'h000, 0);
    chk("to_d9_ready", r0, 1); chk("to_d9_resp", s0, 1); chk("to_d9_cause", c0, 2'b11);
    chk("to_d9_cause_ws2", c2, 2'b11);
    idle(1);
    chk("to_after_ready", r0, 1); chk("to_after_resp", s0, 0);
`else
    for (int d = 1; d < 13; d++) begin
      cyc(1, 1, 2'b10, 12'h004, 0);
      chk($sformatf("hold_d%0d_ready", d), r0, 0);
      chk($sformatf("hold_d%0d_resp", d), s0, 0);
    end
    cyc(1, 1, 2'b10, 12'h004, 1);
    chk("hold_done_ready", r0, 1); chk("hold_done_resp", s0, 0);
    chk("hold_cause_not11", c0 == 2'b11, 0);
    idle(3);
`endif
    idle(2);

    // Reset asserted mid-WAIT
    cyc(1, 1, 2'b10, 12'h004, 0);
    cyc(1, 1, 2'b10, 12'h004, 0); chk("rw_d1_ready", r2, 0);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 12'h000, 1'b0);
    #1;
    chk("rw_ready", r2, 1); chk("rw_resp", s2, 0); chk("rw_pulse", p2, 0);
    chk("rw_cause", c2, 0); chk("rw_ready_ws0", r0, 1);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    idle(1);
    chk("rw_after_ready", r2, 1); chk("rw_after_resp", s2, 0);

    // Reset asserted mid-ERR2
    cyc(1, 1, 2'b11, 12'h000, 1); chk("re_d0_resp", s0, 1);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 12'h000, 1'b1);
    #1;
    chk("re_ready", r0, 1); chk("re_resp", s0, 0); chk("re_cause", c0, 0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    idle(1);
    chk("re_after_ready", r0, 1); chk("re_after_resp", s0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
